// File: rtl/chip8_mem_arbiter.sv
// Single-port access controller for chip8_mem. It shares the memory between the ROM loader,
// the CPU and the sprite (DXYN) engine, and blocks CPU writes into the interpreter/font area.
//
// state | meaning
// IDLE  | mem parked at 0, sample requests, pick winner
// LOAD  | loader byte written this cycle
// CPU   | CPU byte read or (unprotected) write this cycle
// VID   | sprite burst, one byte per cycle, address wraps
module chip8_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = 12'h200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [3:0]        vid_len,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CPU, S_VID} state_t;

  state_t     state;
  logic       rr_vid;
  logic       cpu_wr;
  logic [4:0] cnt;

  // A requester still showing its ack/done this cycle has already been served.
  logic ld_go, cpu_go, vid_go;
  assign ld_go  = ld_req  & ~ld_ack;
  assign cpu_go = cpu_req & ~cpu_ack;
  assign vid_go = vid_req & ~vid_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_vid    <= 1'b0;
      cpu_wr    <= 1'b0;
      cnt       <= 5'd0;
      ld_ack    <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      vid_valid <= 1'b0;
      vid_rdata <= '0;
      vid_done  <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      ld_ack    <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      vid_valid <= 1'b0;
      vid_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          if (ld_go) begin
            state     <= S_LOAD;
            mem_addr  <= ld_addr;
            mem_wdata <= ld_wdata;
            mem_we    <= 1'b1;
          end else if (cpu_go && (!vid_go || !rr_vid)) begin
            state     <= S_CPU;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_we    <= cpu_we && (cpu_addr >= PROT_LIMIT);
            cpu_wr    <= cpu_we;
            rr_vid    <= 1'b1;
          end else if (vid_go) begin
            state    <= S_VID;
            mem_addr <= vid_addr;
            cnt      <= (vid_len == 4'd0) ? 5'd16 : {1'b0, vid_len};
            rr_vid   <= 1'b0;
          end
        end
        S_LOAD: begin
          state     <= S_IDLE;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          ld_ack    <= 1'b1;
        end
        S_CPU: begin
          state     <= S_IDLE;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          cpu_ack   <= 1'b1;
          cpu_err   <= cpu_wr && (mem_addr < PROT_LIMIT);
          if (!cpu_wr) cpu_rdata <= mem_rdata;
        end
        S_VID: begin
          vid_rdata <= mem_rdata;
          vid_valid <= 1'b1;
          if (cnt == 5'd1) begin
            state    <= S_IDLE;
            vid_done <= 1'b1;
            mem_addr <= '0;
            cnt      <= 5'd0;
          end else begin
            cnt      <= cnt - 5'd1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter: stimulus pushes expected events (kind, cycle, data),
// a negedge monitor pops and compares them as ack/valid pulses appear.
module tb_chip8_mem_arbiter;

  localparam int K_LD = 0, K_CPU = 1, K_VID = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
    logic       flag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [7:0]  ld_wdata = '0;
  logic        ld_ack;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_err;
  logic        vid_req = 1'b0;
  logic [11:0] vid_addr = '0;
  logic [3:0]  vid_len = '0;
  logic        vid_valid;
  logic [7:0]  vid_rdata;
  logic        vid_done;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:4095];
  exp_t        exp_q [$];
  logic [7:0]  vq [$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  chip8_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_len(vid_len),
    .vid_valid(vid_valid), .vid_rdata(vid_rdata), .vid_done(vid_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic void push(input int kind, input int c, input logic [7:0] d, input logic f);
    exp_t e;
    e.kind = kind; e.cyc = c; e.data = d; e.flag = f;
    exp_q.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic handle(input int kind, input logic [7:0] d, input logic f);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected event kind", 64'(kind), 64'hFF);
    end else begin
      e = exp_q.pop_front();
      chk("event kind/cycle", {32'(kind), 32'(cyc)}, {32'(e.kind), 32'(e.cyc)});
      if (kind != K_LD) chk("event data/flag", 64'({d, f}), 64'({e.data, e.flag}));
    end
  endtask

  always @(negedge clk) begin
    if (ld_ack)    handle(K_LD, 8'h00, 1'b0);
    if (cpu_ack)   handle(K_CPU, cpu_rdata, cpu_err);
    if (vid_valid) handle(K_VID, vid_rdata, vid_done);
    if (cpu_err && !cpu_ack)  chk("cpu_err without cpu_ack", 64'(cpu_err), 64'h0);
    if (vid_done && !vid_valid) chk("vid_done without vid_valid", 64'(vid_done), 64'h0);
    if (mem_we && mem_addr < 12'h200) chk("write into protected region", 64'(mem_addr), 64'h200);
  end

  function automatic logic [63:0] out_vec();
    return 64'({ld_ack, cpu_ack, cpu_err, cpu_rdata, vid_valid, vid_rdata, vid_done,
                mem_addr, mem_we, mem_wdata});
  endfunction

  task automatic cpu_access(input logic we, input logic [11:0] a, input logic [7:0] wd,
                            input logic [7:0] exp_rd, input logic exp_err, input logic exp_we);
    int k;
    bit seen;
    k = cyc;
    push(K_CPU, k + 2, exp_rd, exp_err);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    step(1);
    chk("cpu serve mem_we/addr", 64'({mem_we, mem_addr}), 64'({exp_we, a}));
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step(1);
      if (cpu_ack) seen = 1;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    if (!seen) chk("cpu_ack timeout", 64'h0, 64'h1);
  endtask

  task automatic vid_burst(input logic [11:0] a, input logic [3:0] len);
    int k, n;
    bit seen;
    k = cyc;
    n = (len == 4'd0) ? 16 : int'(len);
    for (int i = 0; i < n; i++) push(K_VID, k + 2 + i, vq[i], (i == n - 1));
    vid_req = 1'b1; vid_addr = a; vid_len = len;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      step(1);
      if (vid_done) seen = 1;
    end
    vid_req = 1'b0;
    if (!seen) chk("vid_done timeout", 64'h0, 64'h1);
    vq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    mem[12'h050] <= 8'hF0;
    mem[12'h300] <= 8'hC3;
    mem[12'h310] <= 8'h31; mem[12'h311] <= 8'h32; mem[12'h312] <= 8'h33;
    mem[12'hFFE] <= 8'h11; mem[12'hFFF] <= 8'h22; mem[12'h000] <= 8'h33;
    for (int i = 0; i < 16; i++) mem[12'h400 + i] <= 8'h80 + 8'(i);
    for (int i = 0; i < 10; i++) mem[12'h500 + i] <= 8'hA0 + 8'(i);

    #23;
    chk("outputs in reset", out_vec(), 64'h0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("outputs idle after reset", out_vec(), 64'h0);

    // CPU and video contend from reset; loader arrives mid-burst.
    k = cyc;
    push(K_CPU, k + 2, 8'hC3, 1'b0);
    push(K_VID, k + 4, 8'h31, 1'b0);
    push(K_VID, k + 5, 8'h32, 1'b0);
    push(K_VID, k + 6, 8'h33, 1'b1);
    push(K_LD,  k + 8, 8'h00, 1'b0);
    push(K_CPU, k + 10, 8'hC3, 1'b0);
    push(K_VID, k + 12, 8'h31, 1'b0);
    push(K_VID, k + 13, 8'h32, 1'b0);
    push(K_VID, k + 14, 8'h33, 1'b1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h300;
    vid_req = 1'b1; vid_addr = 12'h310; vid_len = 4'd3;
    step(4);
    ld_req = 1'b1; ld_addr = 12'h600; ld_wdata = 8'h66;
    step(4);
    ld_req = 1'b0;
    step(2);
    cpu_req = 1'b0;
    step(4);
    vid_req = 1'b0;
    step(3);
    chk("loader byte in memory", 64'(mem[12'h600]), 64'h66);

    // Loader and CPU read of the same address together: loader first.
    k = cyc;
    push(K_LD,  k + 2, 8'h00, 1'b0);
    push(K_CPU, k + 4, 8'hA2, 1'b0);
    ld_req = 1'b1; ld_addr = 12'h200; ld_wdata = 8'hA2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    step(2);
    ld_req = 1'b0;
    step(2);
    cpu_req = 1'b0;
    step(2);

    // Protected write is blocked, rdata holds the previous read.
    cpu_access(1'b1, 12'h050, 8'h55, 8'hA2, 1'b1, 1'b0);
    step(1);
    cpu_access(1'b0, 12'h050, 8'h00, 8'hF0, 1'b0, 1'b0);
    chk("font byte unchanged", 64'(mem[12'h050]), 64'hF0);
    step(1);
    cpu_access(1'b1, 12'h345, 8'h77, 8'hF0, 1'b0, 1'b1);
    step(1);
    cpu_access(1'b0, 12'h345, 8'h00, 8'h77, 1'b0, 1'b0);
    step(1);
    cpu_access(1'b1, 12'h200, 8'h5A, 8'h77, 1'b0, 1'b1);
    step(1);
    cpu_access(1'b1, 12'h1FF, 8'h5A, 8'h77, 1'b1, 1'b0);
    step(2);

    // Burst wrapping past 0xFFF.
    vq.push_back(8'h11); vq.push_back(8'h22); vq.push_back(8'h33);
    vid_burst(12'hFFE, 4'd3);
    step(2);

    // Length 0 means 16 bytes.
    for (int i = 0; i < 16; i++) vq.push_back(8'h80 + 8'(i));
    vid_burst(12'h400, 4'd0);
    step(2);

    // Reset during the 4th cycle of a 10-byte burst.
    k = cyc;
    push(K_VID, k + 2, 8'hA0, 1'b0);
    push(K_VID, k + 3, 8'hA1, 1'b0);
    vid_req = 1'b1; vid_addr = 12'h500; vid_len = 4'd10;
    step(4);
    chk("outputs busy before reset", 64'(out_vec() != 64'h0), 64'h1);
    rst_n = 1'b0;
    vid_req = 1'b0;
    #1;
    chk("outputs cleared by async reset", out_vec(), 64'h0);
    step(1);
    rst_n = 1'b1;
    step(2);
    for (int i = 0; i < 4; i++) vq.push_back(8'hA0 + 8'(i));
    vid_burst(12'h500, 4'd4);

    step(5);
    chk("all expected events seen", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
